otter_cu_fsm: RTL and testbench

//  Multicycle control sequencer for the OTTER RV32I core. Steps each instruction

---
 rtl/otter_pkg.sv | 39 +++
 rtl/otter_cu_fsm.sv | 170 +++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared definitions for the OTTER control path.
//  opcode_t     RV32I major opcodes, identical to the decoder's enum
//  cu_state_t   control-sequencer state encoding
//  ST_*         the same state encodings as plain localparams for legacy users
//  FUNC12_MRET  ir[31:20] value identifying MRET
//  F3_CSRRW     funct3 value identifying CSRRW
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        CSR    = 7'b1110011
    } opcode_t;

    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_EXEC      = 3'd2;
    localparam logic [2:0] ST_WRITEBACK = 3'd3;
    localparam logic [2:0] ST_INTR      = 3'd4;

    typedef enum logic [2:0] {
        CU_INIT      = ST_INIT,
        CU_FETCH     = ST_FETCH,
        CU_EXEC      = ST_EXEC,
        CU_WRITEBACK = ST_WRITEBACK,
        CU_INTR      = ST_INTR
    } cu_state_t;

    localparam logic [11:0] FUNC12_MRET = 12'h302;
    localparam logic [2:0]  F3_CSRRW    = 3'b001;

endpackage

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle control sequencer for the OTTER RV32I core.
// Steps each instruction through INIT/FETCH/EXEC/WRITEBACK/INTR and decides
// on which cycle each datapath strobe fires; mux selects come from the decoder.
// Ports:
//  CLK, RST                 clock, synchronous active-high reset
//  cu_opcode, func, func12  instruction fields ir[6:0], ir[14:12], ir[31:20]
//  intr, mie                interrupt request (level) and CSR interrupt enable
//  imem_ready, dmem_ready   memory port 1 / port 2 handshakes
//  pc_write .. mret_exec    datapath strobes (combinational from state, inputs)
//  state_o                  current state encoding
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int INIT_CYCLES = 1,
    parameter bit INT_ENABLE  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  cu_opcode,
    input  logic [2:0]  func,
    input  logic [11:0] func12,
    input  logic        intr,
    input  logic        mie,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic        rf_reset,
    output logic        csr_we,
    output logic        int_taken,
    output logic        mret_exec,
    output logic [2:0]  state_o
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    logic [3:0] init_cnt_r;
    logic       int_pending_r;
    logic       trap_s;
    logic       done_s;

    // Trap only from the registered pending flag, so an interrupt is always
    // taken at an instruction boundary and never in the cycle it is raised.
    assign trap_s = int_pending_r & mie & INT_ENABLE;

    // Strobe decode and next-state selection; RST masks every output.
    always_comb begin
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        mem_rden1    = 1'b0;
        mem_rden2    = 1'b0;
        mem_we2      = 1'b0;
        rf_reset     = 1'b0;
        csr_we       = 1'b0;
        int_taken    = 1'b0;
        mret_exec    = 1'b0;
        done_s       = 1'b0;
        next_state_s = state_r;
        if (RST) begin
            next_state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    rf_reset = 1'b1;
                    if (init_cnt_r == INIT_LAST) begin
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_INIT;
                    end
                end
                ST_FETCH: begin
                    mem_rden1 = 1'b1;
                    if (imem_ready) begin
                        next_state_s = ST_EXEC;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    case (opcode_t'(cu_opcode))
                        LOAD: begin
                            mem_rden2    = 1'b1;
                            next_state_s = ST_WRITEBACK;
                        end
                        STORE: begin
                            mem_we2 = 1'b1;
                            if (dmem_ready) begin
                                pc_write = 1'b1;
                                done_s   = 1'b1;
                            end else begin
                                done_s   = 1'b0;
                            end
                        end
                        LUI, AUIPC, JAL, JALR, OP, OP_IMM: begin
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            done_s    = 1'b1;
                        end
                        CSR: begin
                            pc_write = 1'b1;
                            done_s   = 1'b1;
                            if (func == F3_CSRRW) begin
                                csr_we    = 1'b1;
                                reg_write = 1'b1;
                            end else if ((func == 3'b000) && (func12 == FUNC12_MRET)) begin
                                mret_exec = 1'b1;
                            end else begin
                                csr_we    = 1'b0;
                            end
                        end
                        // BRANCH and unknown opcodes only advance the PC.
                        default: begin
                            pc_write = 1'b1;
                            done_s   = 1'b1;
                        end
                    endcase
                end
                ST_WRITEBACK: begin
                    mem_rden2 = 1'b1;
                    if (dmem_ready) begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        done_s    = 1'b1;
                    end else begin
                        done_s    = 1'b0;
                    end
                end
                ST_INTR: begin
                    int_taken    = INT_ENABLE;
                    pc_write     = 1'b1;
                    next_state_s = ST_FETCH;
                end
                default: begin
                    next_state_s = ST_INIT;
                end
            endcase
            if (done_s) begin
                next_state_s = trap_s ? ST_INTR : ST_FETCH;
            end else begin
                done_s = 1'b0;
            end
        end
    end

    assign state_o = RST ? 3'd0 : state_r;

    // State, INIT counter and interrupt-pending flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_INIT;
            init_cnt_r    <= 4'd0;
            int_pending_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + 4'd1;
            end else begin
                init_cnt_r <= 4'd0;
            end
            // Clearing in the INTR cycle wins over a still-high request.
            int_pending_r <= (int_pending_r | intr) & ~int_taken;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
module tb_otter_cu_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  cu_opcode = 7'h00;
    logic [2:0]  func = 3'd0;
    logic [11:0] func12 = 12'h000;
    logic        intr = 1'b0;
    logic        mie = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
    logic        rf_reset, csr_we, int_taken, mret_exec;
    logic [2:0]  state_o;

    // Strobe masks: {pc,reg,rd1,rd2,we2,rfr,csr,int,mret}
    localparam logic [8:0] PC   = 9'h100;
    localparam logic [8:0] RW   = 9'h080;
    localparam logic [8:0] RD1  = 9'h040;
    localparam logic [8:0] RD2  = 9'h020;
    localparam logic [8:0] WE2  = 9'h010;
    localparam logic [8:0] RFR  = 9'h008;
    localparam logic [8:0] CSRW = 9'h004;
    localparam logic [8:0] INT  = 9'h002;
    localparam logic [8:0] MRET = 9'h001;
    localparam logic [8:0] NONE = 9'h000;

    typedef struct {
        string      nm;
        logic [11:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    otter_cu_fsm #(.INIT_CYCLES(3), .INT_ENABLE(1'b1)) dut (
        .CLK(clk), .RST(rst), .cu_opcode(cu_opcode), .func(func), .func12(func12),
        .intr(intr), .mie(mie), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .reg_write(reg_write), .mem_rden1(mem_rden1),
        .mem_rden2(mem_rden2), .mem_we2(mem_we2), .rf_reset(rf_reset),
        .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Monitor: each cycle the DUT presents a strobe vector; compare against scoreboard.
    always @(negedge clk) begin
        logic [11:0] act;
        exp_t        e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, rf_reset,
                   csr_we, int_taken, mret_exec, state_o};
            chk_cnt = chk_cnt + 1;
            if (act === e.v) begin
                pass_cnt = pass_cnt + 1;
            end else begin
                $display("FAIL %s: got strobes=%b state=%0d, expected strobes=%b state=%0d",
                         e.nm, act[11:3], act[2:0], e.v[11:3], e.v[2:0]);
            end
        end
    end

    // Apply one cycle of inputs and queue the expected combinational response.
    task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic [11:0] f12, input logic irq, input logic ie,
                       input logic ir, input logic dr, input logic [2:0] st,
                       input logic [8:0] stb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; cu_opcode = op; func = f3; func12 = f12;
        intr = irq; mie = ie; imem_ready = ir; dmem_ready = dr;
        e.nm = nm;
        e.v  = {stb, st};
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset held two cycles, then three INIT cycles, then FETCH
        cyc(1, 7'h00, 3'd0, 12'h000, 0, 0, 0, 0, 3'd0, NONE, "rst_0");
        cyc(1, 7'h00, 3'd0, 12'h000, 0, 0, 1, 1, 3'd0, NONE, "rst_1");
        for (int i = 0; i < 3; i++)
            cyc(0, 7'h00, 3'd0, 12'h000, 0, 0, 1, 1, 3'd0, RFR, "init");
        // 2: ADD
        cyc(0, 7'h33, 3'd0, 12'h000, 0, 0, 1, 0, 3'd1, RD1, "add_fetch");
        cyc(0, 7'h33, 3'd0, 12'h000, 0, 0, 0, 0, 3'd2, PC | RW, "add_exec");
        // 3: LOAD with ready pulses outside WRITEBACK ignored, 3 wait cycles
        cyc(0, 7'h03, 3'd2, 12'h000, 0, 0, 1, 1, 3'd1, RD1, "ld_fetch");
        cyc(0, 7'h03, 3'd2, 12'h000, 0, 0, 0, 1, 3'd2, RD2, "ld_exec");
        for (int i = 0; i < 3; i++)
            cyc(0, 7'h03, 3'd2, 12'h000, 0, 0, 0, 0, 3'd3, RD2, "ld_wb_wait");
        cyc(0, 7'h03, 3'd2, 12'h000, 0, 0, 0, 1, 3'd3, RD2 | RW | PC, "ld_wb_done");
        // 4: STORE with a fetch stall and two data wait cycles
        cyc(0, 7'h23, 3'd2, 12'h000, 0, 0, 0, 1, 3'd1, RD1, "st_fetch_stall");
        cyc(0, 7'h23, 3'd2, 12'h000, 0, 0, 1, 0, 3'd1, RD1, "st_fetch");
        cyc(0, 7'h23, 3'd2, 12'h000, 0, 0, 0, 0, 3'd2, WE2, "st_wait0");
        cyc(0, 7'h23, 3'd2, 12'h000, 0, 0, 0, 0, 3'd2, WE2, "st_wait1");
        cyc(0, 7'h23, 3'd2, 12'h000, 0, 0, 0, 1, 3'd2, WE2 | PC, "st_done");
        // 5: ADDI with intr high through FETCH and EXEC, mie=1 -> one INTR cycle
        cyc(0, 7'h13, 3'd0, 12'h000, 1, 1, 1, 0, 3'd1, RD1, "irq_fetch");
        cyc(0, 7'h13, 3'd0, 12'h000, 1, 1, 0, 0, 3'd2, PC | RW, "irq_exec");
        cyc(0, 7'h13, 3'd0, 12'h000, 0, 1, 0, 0, 3'd4, INT | PC, "irq_intr");
        // pending is clear again: ADDI with mie=1 goes straight back to FETCH
        cyc(0, 7'h13, 3'd0, 12'h000, 0, 1, 1, 0, 3'd1, RD1, "post_intr_fetch");
        cyc(0, 7'h13, 3'd0, 12'h000, 0, 1, 0, 0, 3'd2, PC | RW, "post_intr_exec");
        // same request with mie=0 -> no trap
        cyc(0, 7'h13, 3'd0, 12'h000, 1, 0, 1, 0, 3'd1, RD1, "mie0_fetch");
        cyc(0, 7'h13, 3'd0, 12'h000, 1, 0, 0, 0, 3'd2, PC | RW, "mie0_exec");
        // 6: MRET
        cyc(0, 7'h73, 3'd0, 12'h302, 0, 0, 1, 0, 3'd1, RD1, "mret_fetch");
        cyc(0, 7'h73, 3'd0, 12'h302, 0, 0, 0, 0, 3'd2, MRET | PC, "mret_exec");
        // reset during a FETCH stall
        cyc(0, 7'h73, 3'd0, 12'h000, 0, 0, 0, 0, 3'd1, RD1, "stall_fetch");
        cyc(1, 7'h73, 3'd0, 12'h000, 0, 0, 0, 0, 3'd0, NONE, "rst_in_stall");
        for (int i = 0; i < 3; i++)
            cyc(0, 7'h73, 3'd1, 12'h000, 0, 1, 1, 0, 3'd0, RFR, "reinit");
        // CSRRW with mie=1: pending left over from mie0 test was cleared by reset
        cyc(0, 7'h73, 3'd1, 12'h000, 0, 1, 1, 0, 3'd1, RD1, "csrrw_fetch");
        cyc(0, 7'h73, 3'd1, 12'h000, 0, 1, 0, 0, 3'd2, CSRW | RW | PC, "csrrw_exec");
        // BRANCH and an unknown opcode only advance the PC
        cyc(0, 7'h63, 3'd0, 12'h000, 0, 1, 1, 0, 3'd1, RD1, "br_fetch");
        cyc(0, 7'h63, 3'd0, 12'h000, 0, 1, 0, 0, 3'd2, PC, "br_exec");
        cyc(0, 7'h7f, 3'd0, 12'h000, 0, 1, 1, 0, 3'd1, RD1, "nop_fetch");
        cyc(0, 7'h7f, 3'd0, 12'h000, 0, 1, 0, 0, 3'd2, PC, "nop_exec");
        cyc(0, 7'h00, 3'd0, 12'h000, 0, 1, 0, 0, 3'd1, RD1, "final_fetch");
        @(negedge clk);
        #1;
        chk_cnt = chk_cnt + 1;
        if (exp_q.size() == 0) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
